// File: rtl/remap_kernel_scheduler_pkg.sv
// Shared types and constants for the kernel remap scheduler.
package remap_pkg;

  localparam int KERNEL_SIZE = 64;
  localparam int DIM_W       = 13;

  // Exponent of a power-of-two value. Anything else rounds up.
  function automatic int log2_int(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int KSHIFT = log2_int(KERNEL_SIZE);
  localparam int COL_W  = DIM_W - KSHIFT;

  localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0] LINE_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    FLUSH     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/remap_kernel_scheduler_if.sv
// Bundle of frame control, remap engine and output stage signals.
// master = frame controller / engine / streamer side, slave = scheduler.
interface remap_kernel_scheduler_if;
  import remap_pkg::*;

  logic [DIM_W-1:0] WIDTH;
  logic [DIM_W-1:0] HEIGHT;
  logic             i_start;
  logic             i_abort;
  logic             o_remap_start;
  logic [COL_W-1:0] o_kernel_col;
  logic [DIM_W-1:0] o_kernel_line;
  logic             o_wr_buf_sel;
  logic             i_remap_done;
  logic             o_kernel_is_remapped;
  logic             o_rd_buf_sel;
  logic             i_kernel_consumed;
  logic             o_busy;
  logic             o_frame_done;
  logic             o_cfg_err;
  logic             o_proto_err;

  modport master (
    output WIDTH, HEIGHT, i_start, i_abort, i_remap_done, i_kernel_consumed,
    input  o_remap_start, o_kernel_col, o_kernel_line, o_wr_buf_sel,
           o_kernel_is_remapped, o_rd_buf_sel, o_busy, o_frame_done,
           o_cfg_err, o_proto_err
  );

  modport slave (
    input  WIDTH, HEIGHT, i_start, i_abort, i_remap_done, i_kernel_consumed,
    output o_remap_start, o_kernel_col, o_kernel_line, o_wr_buf_sel,
           o_kernel_is_remapped, o_rd_buf_sel, o_busy, o_frame_done,
           o_cfg_err, o_proto_err
  );

endinterface

// File: rtl/remap_kernel_scheduler_pos_counter.sv
// Kernel position walker: column within a line, then line, with a flag
// marking the final kernel of the frame.
module remap_kernel_pos_counter
  import remap_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             advance,
  input  logic [COL_W-1:0] kpl_in,
  input  logic [DIM_W-1:0] lines_in,
  output logic [COL_W-1:0] col_idx,
  output logic [DIM_W-1:0] line_idx,
  output logic             last
);

  logic [COL_W-1:0] kpl;
  logic [DIM_W-1:0] lines;
  logic             col_wrap;

  // Detect end of line and end of frame from the current position
  always_comb begin
    col_wrap = (col_idx == (kpl - COL_ONE));
    last     = col_wrap && (line_idx == (lines - LINE_ONE));
  end

  // Latch frame geometry on load, then step through kernels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kpl      <= {COL_W{1'b0}};
      lines    <= {DIM_W{1'b0}};
      col_idx  <= {COL_W{1'b0}};
      line_idx <= {DIM_W{1'b0}};
    end else if (load) begin
      kpl      <= kpl_in;
      lines    <= lines_in;
      col_idx  <= {COL_W{1'b0}};
      line_idx <= {DIM_W{1'b0}};
    end else if (clear) begin
      col_idx  <= {COL_W{1'b0}};
      line_idx <= {DIM_W{1'b0}};
    end else if (advance) begin
      if (col_wrap) begin
        col_idx  <= {COL_W{1'b0}};
        line_idx <= line_idx + LINE_ONE;
      end else begin
        col_idx  <= col_idx + COL_ONE;
      end
    end
  end

endmodule

// File: rtl/remap_kernel_scheduler.sv
// Ping-pong scheduler: issues one remap request per kernel into the free
// buffer and hands completed buffers to the output stage in order.
module remap_kernel_scheduler
  import remap_pkg::*;
(
  input logic                    i_clk,
  input logic                    i_areset,
  remap_kernel_scheduler_if.slave bus
);

  sched_state_t     state, next_state;
  logic [1:0]       buf_full, buf_full_next, set_mask, clr_mask;
  logic             wr_sel, rd_sel;
  logic             remap_start, frame_done, cfg_err, proto_err, busy;
  logic             cfg_ok, start_accept, start_reject, abort_hit;
  logic             done_valid, done_bad, consume_valid, consume_bad;
  logic             issue_go, flush_done;
  logic [COL_W-1:0] col_idx;
  logic [DIM_W-1:0] line_idx;
  logic             last_kernel;

  // Qualify the incoming requests against the current state and flags
  always_comb begin
    cfg_ok = (bus.WIDTH[KSHIFT-1:0] == {KSHIFT{1'b0}}) &&
             (bus.WIDTH[DIM_W-1:KSHIFT] != {COL_W{1'b0}}) &&
             (bus.HEIGHT != {DIM_W{1'b0}});
    start_accept  = (state == IDLE) && bus.i_start && cfg_ok;
    start_reject  = (state == IDLE) && bus.i_start && !cfg_ok;
    abort_hit     = bus.i_abort && (state != IDLE);
    // A done seen while the request pulse is still up cannot belong to it.
    done_valid    = (state == WAIT_DONE) && !remap_start && bus.i_remap_done && !bus.i_abort;
    done_bad      = bus.i_remap_done &&
                    ((state == ISSUE) || (state == FLUSH) ||
                     ((state == WAIT_DONE) && remap_start));
    consume_valid = bus.i_kernel_consumed && buf_full[rd_sel];
    consume_bad   = bus.i_kernel_consumed && !buf_full[rd_sel];
    issue_go      = (state == ISSUE) && !buf_full[wr_sel] && !bus.i_abort;
    flush_done    = (state == FLUSH) && (buf_full == 2'b00) && !bus.i_abort;
  end

  // Next-state selection; abort overrides everything outside IDLE
  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_accept) next_state = ISSUE;
          else              next_state = IDLE;
        end
        ISSUE: begin
          if (issue_go) next_state = WAIT_DONE;
          else          next_state = ISSUE;
        end
        WAIT_DONE: begin
          if (done_valid) begin
            if (last_kernel) next_state = FLUSH;
            else             next_state = ISSUE;
          end else begin
            next_state = WAIT_DONE;
          end
        end
        FLUSH: begin
          if (flush_done) next_state = IDLE;
          else            next_state = FLUSH;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Buffer occupancy: producer sets its buffer, consumer clears its own
  always_comb begin
    set_mask = done_valid    ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    clr_mask = consume_valid ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
    if (abort_hit || start_accept) begin
      buf_full_next = 2'b00;
    end else begin
      buf_full_next = (buf_full | set_mask) & ~clr_mask;
    end
  end

  // State, buffer selects, sticky error and registered output pulses
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state       <= IDLE;
      buf_full    <= 2'b00;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      remap_start <= 1'b0;
      frame_done  <= 1'b0;
      cfg_err     <= 1'b0;
      proto_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      buf_full    <= buf_full_next;
      busy        <= (next_state != IDLE);
      remap_start <= issue_go;
      frame_done  <= flush_done;
      cfg_err     <= start_reject;
      if (abort_hit || start_accept) begin
        wr_sel <= 1'b0;
        rd_sel <= 1'b0;
      end else begin
        wr_sel <= wr_sel ^ done_valid;
        rd_sel <= rd_sel ^ consume_valid;
      end
      if (start_accept) begin
        proto_err <= 1'b0;
      end else if (!abort_hit && (done_bad || consume_bad)) begin
        proto_err <= 1'b1;
      end
    end
  end

  remap_kernel_pos_counter u_pos (
    .clk      (i_clk),
    .rst      (i_areset),
    .load     (start_accept),
    .clear    (abort_hit),
    .advance  (done_valid),
    .kpl_in   (bus.WIDTH[DIM_W-1:KSHIFT]),
    .lines_in (bus.HEIGHT),
    .col_idx  (col_idx),
    .line_idx (line_idx),
    .last     (last_kernel)
  );

  assign bus.o_remap_start        = remap_start;
  assign bus.o_kernel_col         = col_idx;
  assign bus.o_kernel_line        = line_idx;
  assign bus.o_wr_buf_sel         = wr_sel;
  assign bus.o_kernel_is_remapped = buf_full[rd_sel];
  assign bus.o_rd_buf_sel         = rd_sel;
  assign bus.o_busy               = busy;
  assign bus.o_frame_done         = frame_done;
  assign bus.o_cfg_err            = cfg_err;
  assign bus.o_proto_err          = proto_err;

endmodule

// File: tb/tb_remap_kernel_scheduler.sv
// Bench for the kernel remap scheduler: directed scenarios plus randomized
// frames checked against a kernel-count model of the ping-pong scheme.
module tb_remap_kernel_scheduler;
  import remap_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  remap_kernel_scheduler_if bus ();

  remap_kernel_scheduler dut (
    .i_clk    (clk),
    .i_areset (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.i_remap_done = 1'b1;
    step();
    bus.i_remap_done = 1'b0;
  endtask

  task automatic pulse_consume();
    bus.i_kernel_consumed = 1'b1;
    step();
    bus.i_kernel_consumed = 1'b0;
  endtask

  task automatic pulse_start(input int width, input int height);
    bus.WIDTH   = DIM_W'(width);
    bus.HEIGHT  = DIM_W'(height);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic do_abort();
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_remap_start === 1'b1) begin
        found = 1'b1;
        return;
      end
      step();
    end
  endtask

  function automatic logic [27:0] all_outputs();
    return {bus.o_remap_start, bus.o_kernel_col, bus.o_kernel_line, bus.o_wr_buf_sel,
            bus.o_kernel_is_remapped, bus.o_rd_buf_sel, bus.o_busy, bus.o_frame_done,
            bus.o_cfg_err, bus.o_proto_err};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_vec++;
    if (all_outputs() !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", all_outputs());
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (all_outputs() !== 28'd0) begin
      n_err++;
      $display("FAIL reset_idle: got %h want 0", all_outputs());
    end
  endtask

  // Full frame against a model built from kernel counts only.
  task automatic run_frame(input int width, input int height, input int lat_lo,
                           input int lat_hi, input int cd_lo, input int cd_hi);
    int kpl, total, started, done_cnt, cons_cnt, done_due, last_cons, cwait, cdelay, cyc;
    bit drove_done, drove_cons, finished;
    kpl = width / KERNEL_SIZE;
    total = kpl * height;
    started = 0; done_cnt = 0; cons_cnt = 0; done_due = -1; last_cons = -1;
    cwait = 0; cdelay = $urandom_range(cd_hi, cd_lo);
    drove_done = 1'b0; drove_cons = 1'b0; finished = 1'b0; cyc = 0;
    pulse_start(width, height);
    n_vec++;
    if (bus.o_busy !== 1'b1 || bus.o_remap_start !== 1'b0) begin
      n_err++;
      $display("FAIL frame_accept: got busy=%b start=%b want busy=1 start=0",
               bus.o_busy, bus.o_remap_start);
    end
    while (!finished && cyc < 3000) begin
      step();
      cyc++;
      if (drove_done) done_cnt++;
      if (drove_cons) begin
        cons_cnt++;
        if (cons_cnt == total) last_cons = cyc;
      end
      bus.i_remap_done = 1'b0;
      bus.i_kernel_consumed = 1'b0;
      n_vec++;
      if (bus.o_kernel_is_remapped !== ((done_cnt - cons_cnt) > 0)) begin
        n_err++;
        $display("FAIL ready_flag: got %b want %b (done=%0d consumed=%0d)",
                 bus.o_kernel_is_remapped, (done_cnt - cons_cnt) > 0, done_cnt, cons_cnt);
      end
      n_vec++;
      if (bus.o_rd_buf_sel !== cons_cnt[0] || bus.o_proto_err !== 1'b0) begin
        n_err++;
        $display("FAIL rd_sel_proto: got rd=%b perr=%b want rd=%b perr=0",
                 bus.o_rd_buf_sel, bus.o_proto_err, cons_cnt[0]);
      end
      if (cyc == 1) begin
        n_vec++;
        if (bus.o_remap_start !== 1'b1) begin
          n_err++;
          $display("FAIL first_start_latency: got %b want 1", bus.o_remap_start);
        end
      end
      if (bus.o_remap_start === 1'b1) begin
        n_vec++;
        if (started >= total || started - cons_cnt > 1 || started != done_cnt) begin
          n_err++;
          $display("FAIL start_allowed: got start with issued=%0d done=%0d consumed=%0d total=%0d want no start",
                   started, done_cnt, cons_cnt, total);
        end
        n_vec++;
        if (bus.o_kernel_col !== COL_W'(started % kpl) || bus.o_kernel_line !== DIM_W'(started / kpl)
            || bus.o_wr_buf_sel !== started[0]) begin
          n_err++;
          $display("FAIL kernel_coord: got col=%0d line=%0d wr=%b want col=%0d line=%0d wr=%b",
                   bus.o_kernel_col, bus.o_kernel_line, bus.o_wr_buf_sel,
                   started % kpl, started / kpl, started[0]);
        end
        done_due = cyc + $urandom_range(lat_hi, lat_lo);
        started++;
      end
      n_vec++;
      if (bus.o_frame_done !== (last_cons >= 0 && cyc == last_cons + 1)) begin
        n_err++;
        $display("FAIL frame_done: got %b at cycle %0d want %b", bus.o_frame_done, cyc,
                 (last_cons >= 0 && cyc == last_cons + 1));
      end
      n_vec++;
      if (bus.o_busy !== !(last_cons >= 0 && cyc >= last_cons + 1)) begin
        n_err++;
        $display("FAIL busy: got %b at cycle %0d", bus.o_busy, cyc);
      end
      if (last_cons >= 0 && cyc >= last_cons + 1) finished = 1'b1;
      drove_done = 1'b0;
      drove_cons = 1'b0;
      if (!finished && done_due == cyc) begin
        bus.i_remap_done = 1'b1;
        drove_done = 1'b1;
        done_due = -1;
      end
      if (!finished && (done_cnt - cons_cnt) > 0) begin
        if (cwait >= cdelay) begin
          bus.i_kernel_consumed = 1'b1;
          drove_cons = 1'b1;
          cwait = 0;
          cdelay = $urandom_range(cd_hi, cd_lo);
        end else begin
          cwait++;
        end
      end else begin
        cwait = 0;
      end
    end
    n_vec++;
    if (!finished) begin
      n_err++;
      $display("FAIL frame_timeout: got %0d of %0d consumed want all", cons_cnt, total);
    end
    step();
    n_vec++;
    if (bus.o_frame_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL after_frame: got fd=%b busy=%b want 0 0", bus.o_frame_done, bus.o_busy);
    end
  endtask

  task automatic test_basic();
    run_frame(128, 2, 3, 3, 2, 2);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      run_frame(KERNEL_SIZE * $urandom_range(5, 1), $urandom_range(3, 1), 1, 4, 0, 3);
    end
  endtask

  task automatic test_stall();
    int n_starts, due;
    bit found;
    n_starts = 0;
    due = -1;
    pulse_start(128, 2);
    for (int i = 0; i < 30; i++) begin
      step();
      bus.i_remap_done = 1'b0;
      if (bus.o_remap_start === 1'b1) begin
        n_starts++;
        due = i + 2;
      end
      if (i == due) bus.i_remap_done = 1'b1;
    end
    bus.i_remap_done = 1'b0;
    n_vec++;
    if (n_starts != 2 || bus.o_kernel_is_remapped !== 1'b1 || bus.o_rd_buf_sel !== 1'b0
        || bus.o_wr_buf_sel !== 1'b0) begin
      n_err++;
      $display("FAIL stall_hold: got starts=%0d ready=%b rd=%b wr=%b want 2 1 0 0",
               n_starts, bus.o_kernel_is_remapped, bus.o_rd_buf_sel, bus.o_wr_buf_sel);
    end
    pulse_consume();
    n_vec++;
    if (bus.o_rd_buf_sel !== 1'b1 || bus.o_kernel_is_remapped !== 1'b1) begin
      n_err++;
      $display("FAIL stall_consume: got rd=%b ready=%b want 1 1",
               bus.o_rd_buf_sel, bus.o_kernel_is_remapped);
    end
    wait_start(found);
    n_vec++;
    if (!found || bus.o_kernel_col !== COL_W'(0) || bus.o_kernel_line !== DIM_W'(1)
        || bus.o_wr_buf_sel !== 1'b0) begin
      n_err++;
      $display("FAIL stall_third_start: got found=%b col=%0d line=%0d wr=%b want 1 0 1 0",
               found, bus.o_kernel_col, bus.o_kernel_line, bus.o_wr_buf_sel);
    end
    do_abort();
  endtask

  task automatic test_simultaneous();
    bit found;
    pulse_start(128, 2);
    wait_start(found);
    step();
    pulse_done();
    wait_start(found);
    step();
    bus.i_remap_done = 1'b1;
    bus.i_kernel_consumed = 1'b1;
    step();
    bus.i_remap_done = 1'b0;
    bus.i_kernel_consumed = 1'b0;
    n_vec++;
    if (!found || bus.o_rd_buf_sel !== 1'b1 || bus.o_kernel_is_remapped !== 1'b1
        || bus.o_wr_buf_sel !== 1'b0 || bus.o_proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL simultaneous: got found=%b rd=%b ready=%b wr=%b perr=%b want 1 1 1 0 0",
               found, bus.o_rd_buf_sel, bus.o_kernel_is_remapped, bus.o_wr_buf_sel,
               bus.o_proto_err);
    end
    do_abort();
  endtask

  task automatic test_cfg_err();
    int cw[3] = '{100, 0, 128};
    int ch[3] = '{4, 4, 0};
    for (int k = 0; k < 3; k++) begin
      pulse_start(cw[k], ch[k]);
      n_vec++;
      if (bus.o_cfg_err !== 1'b1 || bus.o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_err_pulse: got cfg=%b busy=%b want 1 0 (w=%0d h=%0d)",
                 bus.o_cfg_err, bus.o_busy, cw[k], ch[k]);
      end
      for (int i = 0; i < 4; i++) begin
        step();
        n_vec++;
        if (bus.o_cfg_err !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_remap_start !== 1'b0) begin
          n_err++;
          $display("FAIL cfg_err_idle: got cfg=%b busy=%b start=%b want 0 0 0",
                   bus.o_cfg_err, bus.o_busy, bus.o_remap_start);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit found;
    pulse_start(256, 2);
    for (int k = 0; k < 2; k++) begin
      wait_start(found);
      step();
      pulse_done();
      pulse_consume();
    end
    wait_start(found);
    step();
    do_abort();
    n_vec++;
    if (!found || all_outputs() !== 28'd0) begin
      n_err++;
      $display("FAIL abort_state: got found=%b outputs=%h want 1 0", found, all_outputs());
    end
    pulse_done();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.o_proto_err !== 1'b0 || bus.o_frame_done !== 1'b0 || bus.o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_late_done: got perr=%b fd=%b busy=%b want 0 0 0",
                 bus.o_proto_err, bus.o_frame_done, bus.o_busy);
      end
      step();
    end
  endtask

  task automatic test_proto();
    pulse_consume();
    n_vec++;
    if (bus.o_proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL proto_set: got %b want 1", bus.o_proto_err);
    end
    step();
    n_vec++;
    if (bus.o_proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL proto_sticky: got %b want 1", bus.o_proto_err);
    end
    pulse_start(64, 1);
    n_vec++;
    if (bus.o_proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL proto_clear: got %b want 0", bus.o_proto_err);
    end
    step();
    step();
    pulse_done();
    n_vec++;
    if (bus.o_proto_err !== 1'b0 || bus.o_kernel_is_remapped !== 1'b1) begin
      n_err++;
      $display("FAIL proto_valid_done: got perr=%b ready=%b want 0 1",
               bus.o_proto_err, bus.o_kernel_is_remapped);
    end
    pulse_done();
    n_vec++;
    if (bus.o_proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL proto_extra_done: got %b want 1", bus.o_proto_err);
    end
    do_abort();
  endtask

  task automatic test_async_reset();
    bit found;
    pulse_start(128, 2);
    wait_start(found);
    step();
    pulse_done();
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (all_outputs() !== 28'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0", all_outputs());
    end
    #2;
    rst = 1'b0;
    step();
    pulse_start(128, 2);
    wait_start(found);
    n_vec++;
    if (!found || bus.o_kernel_col !== COL_W'(0) || bus.o_kernel_line !== DIM_W'(0)
        || bus.o_wr_buf_sel !== 1'b0) begin
      n_err++;
      $display("FAIL restart_after_reset: got found=%b col=%0d line=%0d wr=%b want 1 0 0 0",
               found, bus.o_kernel_col, bus.o_kernel_line, bus.o_wr_buf_sel);
    end
    do_abort();
  endtask

  initial begin
    bus.WIDTH = '0;
    bus.HEIGHT = '0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_remap_done = 1'b0;
    bus.i_kernel_consumed = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_simultaneous();
    test_cfg_err();
    test_abort();
    test_proto();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
